// File: rtl/uart_encode.sv
// uart_encode: turns button presses into single-byte ASCII commands for the UART TX FIFO.
// Defining UART_ENCODE_AUTOREPEAT_EN adds auto-repeat while a button is held.
module uart_encode #(
  parameter int REPEAT_DELAY  = 32500000,
  parameter int REPEAT_PERIOD = 6500000,
  parameter int GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnAttack,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  if (GAP_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("uart_encode: GAP_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must all be >= 1");
  end

  // Bit 4 is the highest priority, matching the receive-side decode order.
  logic [4:0]       w_lvl;
  logic [4:0]       w_rise;
  logic [4:0]       w_rep_set;
  logic [4:0]       w_sel;
  logic [4:0]       w_clr;
  logic [4:0]       w_pend_nxt;
  logic [7:0]       w_code;
  logic             w_load;
  state_t           w_state_nxt;
  logic [GAP_W-1:0] w_gap_nxt;

  state_t           r_state;
  logic [GAP_W-1:0] r_gap;
  logic [4:0]       r_prev;
  logic [4:0]       r_pend;
  logic             r_init;
  logic             r_wr;
  logic [7:0]       r_data;
  logic             r_busy;

  function automatic logic [4:0] f_first(input logic [4:0] p);
    logic [4:0] s;
    s = 5'b0;
    if      (p[4]) s = 5'b10000;
    else if (p[3]) s = 5'b01000;
    else if (p[2]) s = 5'b00100;
    else if (p[1]) s = 5'b00010;
    else if (p[0]) s = 5'b00001;
    return s;
  endfunction

  function automatic logic [7:0] f_code(input logic [4:0] s);
    logic [7:0] c;
    c = 8'h00;
    if      (s[4]) c = 8'h77;
    else if (s[3]) c = 8'h73;
    else if (s[2]) c = 8'h61;
    else if (s[1]) c = 8'h64;
    else if (s[0]) c = 8'h20;
    return c;
  endfunction

  assign w_lvl = {btnUp, btnDown, btnLeft, btnRight, btnAttack};
  // The first cycle after reset only captures levels, so a button held through reset is not a press.
  assign w_rise = r_init ? (w_lvl & ~r_prev) : 5'b0;

`ifdef UART_ENCODE_AUTOREPEAT_EN
  localparam int               REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               CNT_W    = $clog2(REP_MAX) + 1;
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  logic [CNT_W-1:0] r_cnt [5];
  logic [4:0]       r_rep;

  always_comb begin
    w_rep_set = 5'b0;
    for (int i = 0; i < 5; i++) begin
      w_rep_set[i] = w_lvl[i] && (r_cnt[i] != '0) &&
                     (r_cnt[i] == (r_rep[i] ? PERIOD_C : DELAY_C));
    end
  end

  // Counter value k means k cycles since the press edge (or since the last repeat).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
      r_rep <= 5'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!w_lvl[i]) begin
          r_cnt[i] <= '0;
          r_rep[i] <= 1'b0;
        end else if (w_rise[i]) begin
          r_cnt[i] <= CNT_W'(1);
          r_rep[i] <= 1'b0;
        end else if (w_rep_set[i]) begin
          r_cnt[i] <= CNT_W'(1);
          r_rep[i] <= 1'b1;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign w_rep_set = 5'b0;
`endif

  assign w_sel  = f_first(r_pend);
  assign w_code = f_code(w_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_clr       = 5'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_pend != 5'b0) && !tx_full) begin
          w_state_nxt = S_WRITE;
          w_clr       = w_sel;
          w_load      = 1'b1;
        end
      end
      S_WRITE: begin
        if (GAP_CYCLES > 1) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        w_gap_nxt = r_gap - GAP_W'(1);
        if (r_gap <= GAP_W'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new request in the same cycle its bit is consumed wins, producing one more byte.
    w_pend_nxt = (r_pend & ~w_clr) | w_rise | w_rep_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_prev  <= 5'b0;
      r_pend  <= 5'b0;
      r_init  <= 1'b0;
      r_wr    <= 1'b0;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_prev  <= w_lvl;
      r_pend  <= w_pend_nxt;
      r_init  <= 1'b1;
      r_wr    <= (w_state_nxt == S_WRITE);
      if (w_load) r_data <= w_code;
      r_busy  <= (w_pend_nxt != 5'b0) || (w_state_nxt != S_IDLE);
    end
  end

  assign wr_uart = r_wr;
  assign w_data  = r_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_uart_encode.sv
// Directed bench for uart_encode: logs every FIFO write with its cycle number and checks
// byte values, ordering, spacing, backpressure, reset behaviour and hold/auto-repeat.
module tb_uart_encode;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnUp = 1'b0;
  logic       btnDown = 1'b0;
  logic       btnLeft = 1'b0;
  logic       btnRight = 1'b0;
  logic       btnAttack = 1'b0;
  logic       tx_full = 1'b0;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;

  uart_encode #(
    .REPEAT_DELAY (100),
    .REPEAT_PERIOD(20),
    .GAP_CYCLES   (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnUp    (btnUp),
    .btnDown  (btnDown),
    .btnLeft  (btnLeft),
    .btnRight (btnRight),
    .btnAttack(btnAttack),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         q_cyc[$];
  logic [7:0] q_dat[$];
  always @(negedge clk) begin
    if (wr_uart) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(w_data);
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int c0, c1, c2, c3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp_d, input int exp_c);
    logic [31:0] od;
    logic [31:0] oc;
    od = (idx < q_dat.size()) ? 32'(q_dat[idx]) : 32'hFFFF_FFFF;
    oc = (idx < q_cyc.size()) ? 32'(q_cyc[idx]) : 32'hFFFF_FFFF;
    chk({tag, "_data"}, od, 32'(exp_d));
    chk({tag, "_cycle"}, oc, 32'(exp_c));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    q_cyc.delete();
    q_dat.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(2);
    chk("rst_wr", wr_uart, 0);
    chk("rst_data", w_data, 8'h00);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    step(5);
    chk("idle_busy", busy, 0);
    chk("idle_count", q_dat.size(), 0);

    // single press of Up
    clear_log();
    btnUp = 1'b1;
    c0 = cyc;
    step(1);
    chk("single_busy", busy, 1);
    step(19);
    btnUp = 1'b0;
    step(20);
    chk("single_count", q_dat.size(), 1);
    chk_byte("single", 0, 8'h77, c0 + 2);
    chk("single_busy_end", busy, 0);

    // simultaneous Attack, Left, Up
    clear_log();
    btnAttack = 1'b1;
    btnLeft   = 1'b1;
    btnUp     = 1'b1;
    c0 = cyc;
    step(3);
    btnAttack = 1'b0;
    btnLeft   = 1'b0;
    btnUp     = 1'b0;
    step(20);
    chk("simul_count", q_dat.size(), 3);
    chk_byte("simul0", 0, 8'h77, c0 + 2);
    chk_byte("simul1", 1, 8'h61, c0 + 7);
    chk_byte("simul2", 2, 8'h20, c0 + 12);
    chk("simul_hold", w_data, 8'h20);

    // backpressure with Right and Down
    clear_log();
    tx_full  = 1'b1;
    btnRight = 1'b1;
    btnDown  = 1'b1;
    step(2);
    btnRight = 1'b0;
    btnDown  = 1'b0;
    step(18);
    chk("bp_blocked_count", q_dat.size(), 0);
    chk("bp_blocked_busy", busy, 1);
    tx_full = 1'b0;
    c1 = cyc;
    step(9);
    chk("bp_busy_gap", busy, 1);
    step(1);
    chk("bp_busy_fall", busy, 0);
    step(5);
    chk("bp_count", q_dat.size(), 2);
    chk_byte("bp0", 0, 8'h73, c1 + 1);
    chk_byte("bp1", 1, 8'h64, c1 + 6);
    chk("bp_hold", w_data, 8'h64);

    // Down edge in the same cycle its pending bit is consumed
    clear_log();
    tx_full = 1'b1;
    btnDown = 1'b1;
    step(1);
    btnDown = 1'b0;
    step(5);
    btnDown = 1'b1;
    tx_full = 1'b0;
    c2 = cyc;
    step(2);
    btnDown = 1'b0;
    step(20);
    chk("coll_count", q_dat.size(), 2);
    chk_byte("coll0", 0, 8'h73, c2 + 1);
    chk_byte("coll1", 1, 8'h73, c2 + 6);

    // reset during a write, Up held through reset release
    clear_log();
    btnRight = 1'b1;
    c0 = cyc;
    step(1);
    btnRight = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_wr_before", wr_uart, 1);
    chk("mid_data_before", w_data, 8'h64);
    rst   = 1'b0;
    btnUp = 1'b1;
    #1;
    chk("mid_wr_reset", wr_uart, 0);
    chk("mid_data_reset", w_data, 8'h00);
    chk("mid_busy_reset", busy, 0);
    clear_log();
    step(2);
    rst = 1'b1;
    step(30);
    chk("held_count", q_dat.size(), 0);
    chk("held_busy", busy, 0);
    btnUp = 1'b0;
    step(3);
    btnUp = 1'b1;
    c3 = cyc;
    step(3);
    btnUp = 1'b0;
    step(10);
    chk("repress_count", q_dat.size(), 1);
    chk_byte("repress", 0, 8'h77, c3 + 2);

    // long hold of Left
    clear_log();
    btnLeft = 1'b1;
    c0 = cyc;
    step(195);
    btnLeft = 1'b0;
    step(30);
`ifdef UART_ENCODE_AUTOREPEAT_EN
    chk("hold_count", q_dat.size(), 6);
    chk_byte("hold0", 0, 8'h61, c0 + 2);
    chk_byte("hold1", 1, 8'h61, c0 + 102);
    chk_byte("hold2", 2, 8'h61, c0 + 122);
    chk_byte("hold3", 3, 8'h61, c0 + 142);
    chk_byte("hold4", 4, 8'h61, c0 + 162);
    chk_byte("hold5", 5, 8'h61, c0 + 182);
`else
    chk("hold_count", q_dat.size(), 1);
    chk_byte("hold0", 0, 8'h61, c0 + 2);
`endif
    chk("hold_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_encode.md
Name: uart_encode

Overview:
- Transmit-side counterpart of the keyboard-command path. Turns local button activity into the same single-byte ASCII command codes the UART receive path understands.
- Byte map: 'w' 0x77 Up, 's' 0x73 Down, 'a' 0x61 Left, 'd' 0x64 Right, space 0x20 Attack.
- Sits between the synchronized/debounced button inputs and the UART TX FIFO write port (wr_uart/w_data/tx_full). Lets one board drive another board's game over the serial link.

Parameters:
- REPEAT_DELAY, 32500000, cycles a button must stay held after its press byte before the first auto-repeat byte (0.5 s at 65 MHz).
- REPEAT_PERIOD, 6500000, cycles between subsequent auto-repeat bytes while held (0.1 s at 65 MHz).
- GAP_CYCLES, 16, minimum idle cycles after each FIFO write before the next write; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btnUp  input  1  level, already synchronized to clk.
- btnDown  input  1  level, already synchronized.
- btnLeft  input  1  level, already synchronized.
- btnRight  input  1  level, already synchronized.
- btnAttack  input  1  level, already synchronized.
- tx_full  input  1  TX FIFO full flag.
- wr_uart  output  1  one-cycle FIFO write strobe, registered.
- w_data  output  8  byte to write, valid while wr_uart=1, registered.
- busy  output  1  high when any pending bit is set or FSM is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): wr_uart=0, w_data=8'h00, busy=0, FSM=IDLE, pending[4:0]=0, all repeat counters=0, previous-level registers=0.
  - A button already held when reset releases produces no byte until it is released and pressed again.
- Edge detect:
  - Per button, prev register; rising edge = level & ~prev.
  - A rising edge sets that button's pending bit.
  - Falling edge has no byte; it clears the button's repeat counter.
- Priority: Up > Down > Left > Right > Attack (fixed, identical to receive-side decode order).
- FSM states:
  - IDLE:
    - If pending!=0 and tx_full=0 -> WRITE; latch the code of the highest-priority pending bit into w_data; clear that pending bit.
    - Otherwise stay in IDLE.
  - WRITE: wr_uart=1 for exactly this one cycle -> GAP; gap counter loaded with GAP_CYCLES-1.
  - GAP: wr_uart=0; count down to 0 -> IDLE.
- Latency: pending set at edge N -> wr_uart high in cycle N+2 (IDLE->WRITE transition at N+1) when FIFO not full and FSM idle.
- tx_full:
  - Sampled only in IDLE. While it is 1, pending bits are held and nothing is dropped.
  - tx_full can rise only from this block's writes. A WRITE entered with tx_full=0 is therefore always accepted.
- Simultaneous events:
  - Multiple edges in one cycle: all pending bits set; bytes are emitted in priority order, one per WRITE+GAP window.
  - Edge on a button in the same cycle its pending bit is cleared: pending stays 1 (set wins), yielding one extra byte.
  - A repeated edge while its pending bit is already 1 is coalesced (no counting).
- w_data holds its last value between writes.
- busy = (pending!=0) | (state!=IDLE), registered.

Optional Feature:
- Macro: UART_ENCODE_AUTOREPEAT_EN.
- Defined:
  - Each button has a counter (width $clog2 of the larger of REPEAT_DELAY/REPEAT_PERIOD, +1), zero while released.
  - The counter starts at the press edge. On reaching REPEAT_DELAY it sets pending and reloads to count REPEAT_PERIOD; it repeats while held.
  - Counters keep running while tx_full=1; repeat requests coalesce in pending.
- Not defined: counters are absent; exactly one byte per press.

Test Plan:
- Bench uses REPEAT_DELAY=100, REPEAT_PERIOD=20, GAP_CYCLES=4.
- Reset mid-write: assert rst=0 during WRITE -> wr_uart=0, w_data=0x00 immediately; hold btnUp through reset release -> no byte until release and re-press.
- Single press: btnUp 0->1 at cycle 10, tx_full=0 -> wr_uart=1 with w_data=0x77 at cycle 12 only; release -> no further bytes (macro off).
- Simultaneous press: btnAttack, btnLeft, btnUp rise same cycle -> bytes 0x77, 0x61, 0x20 in that order, consecutive wr_uart pulses exactly 5 cycles apart.
- Backpressure: tx_full=1, press btnRight and btnDown -> no wr_uart; drop tx_full -> 0x73 then 0x64, none lost, busy falls after the final GAP.
- Set/clear collision: btnDown edge exactly in cycle its pending clears -> two 0x73 bytes total.
- Auto-repeat (macro on): hold btnLeft 200 cycles -> 0x61 at press, then at +100, +120, +140, +160, +180 cycles after press edge (6 bytes); release -> stop.
